// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU port A, loader port B, MMU memory port, run/halt.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_arbiter_if;
  logic        run;
  logic        a_req;
  logic        a_we;
  logic [15:0] a_addr;
  logic [7:0]  a_wdata;
  logic        a_ack;
  logic        b_req;
  logic        b_we;
  logic [15:0] b_addr;
  logic [7:0]  b_wdata;
  logic        b_ack;
  logic [7:0]  rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic        hlt;

  modport slave (
    input  run, a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata, mem_rdata,
    output a_ack, b_ack, rdata, mem_addr, mem_wdata, mem_write, hlt
  );

  modport master (
    output run, a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata, mem_rdata,
    input  a_ack, b_ack, rdata, mem_addr, mem_wdata, mem_write, hlt
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single MMU memory port between the CPU (port A) and the loader (port B),
// running each access through a fixed-latency IDLE -> ACCESS -> DONE sequence.
//
// state  | meaning
// IDLE   | nothing in flight; arbitrate eligible requests
// ACCESS | winner's address/data on the mmu port; down-counter times MEM_LAT cycles
// DONE   | ack to the granted port for exactly this cycle; requests ignored
module mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int B_PRIORITY = 0
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic        last_b;
  logic        we_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        write_q;
  logic        elig_a;
  logic        elig_b;
  logic        grant;
  logic        pick_b;
  logic        term;
  logic        owned_a;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    pick_b   = 1'b0;
    term     = 1'b0;
    elig_a   = bus.a_req & bus.run;
    elig_b   = bus.b_req;
    case (state)
      S_IDLE: begin
        if (elig_a | elig_b) begin
          grant    = 1'b1;
          state_nx = S_ACCESS;
          // On contention: fixed B priority, or the port not served last time.
          if (elig_a & elig_b) pick_b = (B_PRIORITY != 0) ? 1'b1 : ~last_b;
          else                 pick_b = elig_b;
        end
      end
      S_ACCESS: begin
        if (cnt == 4'd0) begin
          term     = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      write_q <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= 8'h00;
      last_b  <= 1'b0;
      cnt     <= 4'd0;
    end else if (grant) begin
      addr_q  <= pick_b ? bus.b_addr  : bus.a_addr;
      wdata_q <= pick_b ? bus.b_wdata : bus.a_wdata;
      write_q <= pick_b ? bus.b_we    : bus.a_we;
      we_q    <= pick_b ? bus.b_we    : bus.a_we;
      last_b  <= pick_b;
      cnt     <= CNT_LOAD;
    end else if (state == S_ACCESS) begin
      if (term) begin
        write_q <= 1'b0;
        if (!we_q) rdata_q <= bus.mem_rdata;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // last_b doubles as the owner of the access in flight.
  assign owned_a       = ((state == S_ACCESS) || (state == S_DONE)) && !last_b;
  assign bus.a_ack     = (state == S_DONE) && !last_b;
  assign bus.b_ack     = (state == S_DONE) && last_b;
  assign bus.hlt       = ~bus.run & ~owned_a;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_write = write_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: round-robin instance with a memory model and
// ack scoreboard, plus a B-priority instance for the starvation scenario.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter_if pbus ();

  mem_arbiter #(.MEM_LAT(2), .B_PRIORITY(0)) dut   (.clk(clk), .rst(rst), .bus(bus));
  mem_arbiter #(.MEM_LAT(2), .B_PRIORITY(1)) dut_p (.clk(clk), .rst(rst), .bus(pbus));

  logic [7:0] mem [0:65535];

  always @(posedge clk) begin
    if (rst) begin
      mem[16'h1234] <= 8'h5A;
      mem[16'h2000] <= 8'h77;
      mem[16'h3000] <= 8'h11;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata  = mem[bus.mem_addr];
  assign pbus.mem_rdata = pbus.mem_addr[7:0];

  typedef struct {
    bit         port_b;
    bit         we;
    logic [7:0] rd;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rd_hold = 8'h00;

  function automatic exp_t mk(input bit port_b, input bit we, input logic [7:0] rd);
    exp_t e;
    e.port_b = port_b;
    e.we     = we;
    e.rd     = rd;
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_hold = 8'h00;
      end else if (bus.a_ack === 1'b1 || bus.b_ack === 1'b1) begin
        checks++;
        if (bus.a_ack === 1'b1 && bus.b_ack === 1'b1) begin
          failures++;
          $display("FAIL dual_ack: a_ack=1 b_ack=1, required only one");
        end
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_ack: a_ack=%b b_ack=%b, required no ack", bus.a_ack, bus.b_ack);
        end else begin
          e = sb.pop_front();
          checks++;
          if (bus.b_ack !== e.port_b) begin
            failures++;
            $display("FAIL sb_port: b_ack=%b, required %b", bus.b_ack, e.port_b);
          end
          if (!e.we) rd_hold = e.rd;
          checks++;
          if (bus.rdata !== rd_hold) begin
            failures++;
            $display("FAIL sb_rdata: got %h, required %h", bus.rdata, rd_hold);
          end
        end
      end
    end
  endtask

  task automatic wait_ack(input bit port_b, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if ((port_b ? bus.b_ack : bus.a_ack) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if (bus.a_ack !== 1'b0 || bus.b_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_acks: a=%b b=%b, required 0 0", bus.a_ack, bus.b_ack);
    end
    checks++;
    if (bus.mem_write !== 1'b0 || bus.mem_addr !== 16'h0000 || bus.mem_wdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_mem: write=%b addr=%h wdata=%h, required 0 0000 00",
               bus.mem_write, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.rdata !== 8'h00 || bus.hlt !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdata_hlt: rdata=%h hlt=%b, required 00 0", bus.rdata, bus.hlt);
    end
    checks++;
    if (pbus.mem_write !== 1'b0 || pbus.a_ack !== 1'b0 || pbus.b_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_prio: write=%b a=%b b=%b, required 0 0 0",
               pbus.mem_write, pbus.a_ack, pbus.b_ack);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single_read();
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h1234; bus.a_wdata = 8'hEE;
    sb.push_back(mk(1'b0, 1'b0, 8'h5A));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.mem_addr !== 16'h1234 || bus.mem_write !== 1'b0 || bus.a_ack !== 1'b0) begin
        failures++;
        $display("FAIL read_access[%0d]: addr=%h write=%b ack=%b, required 1234 0 0",
                 i, bus.mem_addr, bus.mem_write, bus.a_ack);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.a_ack !== 1'b1 || bus.rdata !== 8'h5A) begin
      failures++;
      $display("FAIL read_ack: ack=%b rdata=%h, required 1 5a", bus.a_ack, bus.rdata);
    end
    bus.a_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.a_ack !== 1'b0) begin
      failures++;
      $display("FAIL read_ack_pulse: ack=%b, required 0", bus.a_ack);
    end
    idle(1);
  endtask

  task automatic test_write();
    int n;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 16'h5555; bus.a_wdata = 8'hAB;
    sb.push_back(mk(1'b0, 1'b1, 8'h00));
    @(posedge clk); #1;
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_addr !== 16'h5555 || bus.mem_wdata !== 8'hAB) begin
      failures++;
      $display("FAIL write_access: write=%b addr=%h wdata=%h, required 1 5555 ab",
               bus.mem_write, bus.mem_addr, bus.mem_wdata);
    end
    wait_ack(1'b0, n);
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL write_latency: %0d, required 2", n);
    end
    checks++;
    if (bus.mem_write !== 1'b0 || mem[16'h5555] !== 8'hAB) begin
      failures++;
      $display("FAIL write_done: write=%b mem=%h, required 0 ab", bus.mem_write, mem[16'h5555]);
    end
    bus.a_req = 1'b0;
    idle(1);
    bus.a_req = 1'b1; bus.a_we = 1'b0;
    sb.push_back(mk(1'b0, 1'b0, 8'hAB));
    wait_ack(1'b0, n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL readback_latency: %0d, required 3", n);
    end
    bus.a_req = 1'b0;
    idle(2);
  endtask

  task automatic test_contention();
    int n;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 16'h0100; bus.b_wdata = 8'hC3;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h2000;
    sb.push_back(mk(1'b1, 1'b1, 8'h00));
    sb.push_back(mk(1'b0, 1'b0, 8'h77));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.mem_write !== 1'b1 || bus.mem_addr !== 16'h0100 || bus.mem_wdata !== 8'hC3) begin
        failures++;
        $display("FAIL contend_b_access[%0d]: write=%b addr=%h wdata=%h, required 1 0100 c3",
                 i, bus.mem_write, bus.mem_addr, bus.mem_wdata);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.b_ack !== 1'b1 || bus.mem_write !== 1'b0 || mem[16'h0100] !== 8'hC3) begin
      failures++;
      $display("FAIL contend_b_ack: ack=%b write=%b mem=%h, required 1 0 c3",
               bus.b_ack, bus.mem_write, mem[16'h0100]);
    end
    bus.b_req = 1'b0;
    wait_ack(1'b0, n);
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL contend_a_spacing: %0d, required 4", n);
    end
    bus.a_req = 1'b0;
    idle(2);
  endtask

  task automatic test_halt();
    int n;
    bus.run = 1'b0; bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h3000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.a_ack !== 1'b0 || bus.mem_write !== 1'b0 || bus.hlt !== 1'b1) begin
        failures++;
        $display("FAIL halt_hold[%0d]: ack=%b write=%b hlt=%b, required 0 0 1",
                 i, bus.a_ack, bus.mem_write, bus.hlt);
      end
    end
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 16'h0100;
    sb.push_back(mk(1'b1, 1'b0, 8'hC3));
    wait_ack(1'b1, n);
    checks++;
    if (n !== 3 || bus.hlt !== 1'b1) begin
      failures++;
      $display("FAIL halt_b_read: latency=%0d hlt=%b, required 3 1", n, bus.hlt);
    end
    bus.b_req = 1'b0;
    bus.run = 1'b1;
    sb.push_back(mk(1'b0, 1'b0, 8'h11));
    @(posedge clk); #1;
    checks++;
    if (bus.hlt !== 1'b0) begin
      failures++;
      $display("FAIL run_hlt: hlt=%b, required 0", bus.hlt);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.mem_addr !== 16'h3000) begin
      failures++;
      $display("FAIL run_grant_a: addr=%h, required 3000", bus.mem_addr);
    end
    bus.run = 1'b0;
    #1;
    checks++;
    if (bus.hlt !== 1'b0) begin
      failures++;
      $display("FAIL halt_inflight: hlt=%b, required 0", bus.hlt);
    end
    wait_ack(1'b0, n);
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL halt_inflight_ack: %0d, required 2", n);
    end
    bus.a_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.hlt !== 1'b1) begin
      failures++;
      $display("FAIL halt_after: hlt=%b, required 1", bus.hlt);
    end
    bus.run = 1'b1;
    idle(1);
  endtask

  task automatic test_rr_alternate();
    int n;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h2000;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 16'h0100;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(1'b1, 1'b0, 8'hC3));
      sb.push_back(mk(1'b0, 1'b0, 8'h77));
    end
    for (int i = 0; i < 4; i++) begin
      n = -1;
      for (int j = 1; j <= 40; j++) begin
        @(posedge clk); #1;
        if (bus.a_ack === 1'b1 || bus.b_ack === 1'b1) begin
          n = j;
          break;
        end
      end
      checks++;
      if (n !== ((i == 0) ? 3 : 4)) begin
        failures++;
        $display("FAIL rr_spacing[%0d]: %0d, required %0d", i, n, (i == 0) ? 3 : 4);
      end
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    idle(2);
  endtask

  task automatic test_priority();
    int na;
    int nb;
    na = 0;
    nb = 0;
    pbus.a_req = 1'b1; pbus.a_we = 1'b0; pbus.a_addr = 16'h0011;
    pbus.b_req = 1'b1; pbus.b_we = 1'b0; pbus.b_addr = 16'h0022;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (pbus.a_ack === 1'b1) na++;
      if (pbus.b_ack === 1'b1) nb++;
    end
    checks++;
    if (na !== 0 || nb !== 5) begin
      failures++;
      $display("FAIL prio_starve: a_acks=%0d b_acks=%0d, required 0 5", na, nb);
    end
    checks++;
    if (pbus.rdata !== 8'h22) begin
      failures++;
      $display("FAIL prio_rdata: %h, required 22", pbus.rdata);
    end
    pbus.a_req = 1'b0;
    pbus.b_req = 1'b0;
    idle(2);
  endtask

  task automatic test_reset_mid_access();
    int n;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 16'h0400; bus.b_wdata = 8'h99;
    @(posedge clk); #1;
    checks++;
    if (bus.mem_write !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_access: write=%b, required 1", bus.mem_write);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.b_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.mem_write !== 1'b0 || bus.b_ack !== 1'b0 || bus.a_ack !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_abort: write=%b b_ack=%b a_ack=%b, required 0 0 0",
               bus.mem_write, bus.b_ack, bus.a_ack);
    end
    checks++;
    if (bus.mem_addr !== 16'h0000 || bus.mem_wdata !== 8'h00 || bus.rdata !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_outputs: addr=%h wdata=%h rdata=%h, required 0000 00 00",
               bus.mem_addr, bus.mem_wdata, bus.rdata);
    end
    rst = 1'b0;
    idle(3);
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h1234;
    sb.push_back(mk(1'b0, 1'b0, 8'h5A));
    wait_ack(1'b0, n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL rstmid_fresh: %0d, required 3", n);
    end
    bus.a_req = 1'b0;
    idle(2);
  endtask

  task automatic test_back_to_back();
    int n;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h1234;
    sb.push_back(mk(1'b0, 1'b0, 8'h5A));
    sb.push_back(mk(1'b0, 1'b0, 8'h77));
    @(posedge clk); #1;
    bus.a_addr = 16'h2000;
    @(posedge clk); #1;
    checks++;
    if (bus.mem_addr !== 16'h1234) begin
      failures++;
      $display("FAIL b2b_latched: addr=%h, required 1234", bus.mem_addr);
    end
    wait_ack(1'b0, n);
    checks++;
    if (n !== 1) begin
      failures++;
      $display("FAIL b2b_first: %0d, required 1", n);
    end
    wait_ack(1'b0, n);
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL b2b_spacing: %0d, required 4", n);
    end
    bus.a_req = 1'b0;
    idle(3);
  endtask

  initial begin
    bus.run = 1'b1;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 16'h0000; bus.a_wdata = 8'h00;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 16'h0000; bus.b_wdata = 8'h00;
    pbus.run = 1'b1;
    pbus.a_req = 1'b0; pbus.a_we = 1'b0; pbus.a_addr = 16'h0000; pbus.a_wdata = 8'h00;
    pbus.b_req = 1'b0; pbus.b_we = 1'b0; pbus.b_addr = 16'h0000; pbus.b_wdata = 8'h00;
    fork
      monitor();
    join_none
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_halt();
    test_rr_alternate();
    test_priority();
    test_reset_mid_access();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d acks outstanding, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
